// File: rtl/cnn_io_pkg.sv
// cnn_io_pkg
//   Shared definitions for the CNN accelerator I/O front end: the
//   coordinator state encoding, the host-visible header layout and the
//   timing constants of the compressed-image stream.
package cnn_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM_HI,
        ST_PARAM_LO,
        ST_IMG_FETCH,
        ST_IMG_RUN,
        ST_IMG_GAP
    } state_t;

    // Header layout (byte addresses). Written and read by the host only.
    localparam int HDR_FILTER_SIZE = 0;
    localparam int HDR_NUM_LAYERS  = 1;
    localparam int HDR_FILT_OFS    = 2;  // 2 bytes, MSB first
    localparam int HDR_DENSE_OFS   = 4;  // 2 bytes, MSB first
    localparam int HDR_COUNTS      = 6;  // per-layer filter counts, then dense counts

    // One compressed image word is consumed every IMG_WORD_CYCLES clocks.
    localparam int IMG_WORD_CYCLES = 34;
    localparam int MAX_RUN         = 32;

endpackage

// File: rtl/cnn_io_ram.sv
// cnn_io_ram
//   Byte-wide parameter/image RAM with one write port and one registered
//   read port. A read of the address being written returns the old byte.
// Ports:
//   clk      - rising-edge clock
//   i_rst_n  - synchronous active-low reset (read register only)
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write byte
//   i_re     - read strobe; o_rdata holds when low
//   i_raddr  - read address
//   o_rdata  - registered read byte (1-cycle latency)
module cnn_io_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Storage is never cleared; reset only affects the read register.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn_io_coordinator.sv
// cnn_io_coordinator
//   I/O front end of the DCNN accelerator. Arbitrates the single RAM write
//   port between host byte writes, big-endian 16-bit parameter loads and
//   run-length image decompression, and reports status.
// Ports:
//   clk         - rising-edge clock
//   RST         - synchronous reset, active-low
//   interrupt   - synchronous abort of image operations (priority over load)
//   load, cnn   - load=1: cnn=1 parameter load, cnn=0 compressed image load
//   Din         - parameter word / compressed word {run, value}
//   Dout        - status {error, image_loaded, params_loaded, decompressing}
//   ramAddress  - host byte address / parameter base / image start pointer
//   ramDataIn   - host write byte
//   ramDataOut  - registered host read byte
//   readSignal  - host read strobe (always served)
//   writeSignal - host write strobe (ignored while load=1)
module cnn_io_coordinator #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = cnn_io_pkg::MAX_RUN
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                interrupt,
    input  logic                load,
    input  logic                cnn,
    input  logic [2*DATA_W-1:0] Din,
    output logic [3:0]          Dout,
    input  logic [ADDR_W-1:0]   ramAddress,
    input  logic [DATA_W-1:0]   ramDataIn,
    output logic [DATA_W-1:0]   ramDataOut,
    input  logic                readSignal,
    input  logic                writeSignal
);

    import cnn_io_pkg::*;

    localparam int CYC_W = $clog2(IMG_WORD_CYCLES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_run;
    logic [DATA_W-1:0] r_value;
    logic [CYC_W-1:0]  r_cyc;
    logic              r_dec;
    logic              r_par_done;
    logic              r_img_done;
    logic              r_err;

    logic              w_par_mode;
    logic              w_img_mode;
    logic              w_par_wr_hi;
    logic              w_par_wr_lo;
    logic              w_img_wr;
    logic              w_host_wr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_din_hi;
    logic [DATA_W-1:0] w_din_lo;

    function automatic logic [DATA_W-1:0] sat_run(input logic [DATA_W-1:0] run);
        if (run > DATA_W'(MAX_RUN)) begin
            return DATA_W'(MAX_RUN);
        end
        return run;
    endfunction

    assign w_din_hi   = Din[2*DATA_W-1:DATA_W];
    assign w_din_lo   = Din[DATA_W-1:0];
    assign w_par_mode = load & cnn;
    assign w_img_mode = load & ~cnn;

    // IDLE doubles as the HI phase of the first parameter word so that the
    // host's two-cycle hold of each word lines up with load rising.
    assign w_par_wr_hi = RST & ~interrupt & w_par_mode &
                         ((r_state == ST_IDLE) || (r_state == ST_PARAM_HI));
    assign w_par_wr_lo = RST & ~interrupt & w_par_mode & (r_state == ST_PARAM_LO);
    // A run in progress completes even after load falls.
    assign w_img_wr    = RST & ~interrupt & (r_state == ST_IMG_RUN);
    assign w_host_wr   = RST & ~load & writeSignal;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = ramAddress;
        w_wdata = ramDataIn;
        if (w_par_wr_hi) begin
            w_we    = 1'b1;
            w_wdata = w_din_hi;
        end else if (w_par_wr_lo) begin
            w_we    = 1'b1;
            w_waddr = ramAddress + ADDR_W'(1);
            w_wdata = w_din_lo;
        end else if (w_img_wr) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = r_value;
        end else if (w_host_wr) begin
            w_we    = 1'b1;
        end
    end

    cnn_io_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .i_rst_n(RST),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_re   (readSignal),
        .i_raddr(ramAddress),
        .o_rdata(ramDataOut)
    );

    // r_cyc indexes the current clock within the word slot: 0 is FETCH, the
    // run occupies 1..run, and GAP pads out to IMG_WORD_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_run      <= '0;
            r_cyc      <= '0;
            r_dec      <= 1'b0;
            r_par_done <= 1'b0;
            r_img_done <= 1'b0;
            r_err      <= 1'b0;
        end else if (interrupt) begin
            r_state    <= ST_IDLE;
            r_dec      <= 1'b0;
            r_img_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_par_mode) begin
                        r_state <= ST_PARAM_LO;
                    end else if (w_img_mode) begin
                        r_state <= ST_IMG_FETCH;
                        r_ptr   <= ramAddress;
                        r_cyc   <= '0;
                    end
                end
                ST_PARAM_HI, ST_PARAM_LO: begin
                    // A cnn toggle ends the load just like load falling.
                    if (!w_par_mode) begin
                        r_state    <= ST_IDLE;
                        r_par_done <= 1'b1;
                    end else begin
                        r_state <= (r_state == ST_PARAM_HI) ? ST_PARAM_LO : ST_PARAM_HI;
                    end
                end
                ST_IMG_FETCH: begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    if (!w_img_mode) begin
                        r_state    <= ST_IDLE;
                        r_img_done <= 1'b1;
                    end else begin
                        r_run   <= sat_run(w_din_hi);
                        r_value <= w_din_lo;
                        if (w_din_hi > DATA_W'(MAX_RUN)) begin
                            r_err <= 1'b1;
                        end
                        if (w_din_hi == '0) begin
                            r_state <= ST_IMG_GAP;
                        end else begin
                            r_state <= ST_IMG_RUN;
                            r_dec   <= 1'b1;
                        end
                    end
                end
                ST_IMG_RUN: begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    r_ptr <= r_ptr + ADDR_W'(1);
                    r_run <= r_run - DATA_W'(1);
                    if (r_run == DATA_W'(1)) begin
                        r_dec <= 1'b0;
                        if (!w_img_mode) begin
                            r_state    <= ST_IDLE;
                            r_img_done <= 1'b1;
                        end else begin
                            r_state <= ST_IMG_GAP;
                        end
                    end
                end
                ST_IMG_GAP: begin
                    if (!w_img_mode) begin
                        r_state    <= ST_IDLE;
                        r_img_done <= 1'b1;
                    end else if (r_cyc == CYC_W'(IMG_WORD_CYCLES - 1)) begin
                        r_state <= ST_IMG_FETCH;
                        r_cyc   <= '0;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Dout = {r_err, r_img_done, r_par_done, r_dec};

endmodule

// File: tb/tb_cnn_io_coordinator.sv
module tb_cnn_io_coordinator;
    import cnn_io_pkg::*;

    localparam int MAXR     = 32;
    localparam int WORD_CYC = 34;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        interrupt = 1'b0;
    logic        load = 1'b0;
    logic        cnn = 1'b0;
    logic [15:0] Din = '0;
    logic [3:0]  Dout;
    logic [15:0] ramAddress = '0;
    logic [7:0]  ramDataIn = '0;
    logic [7:0]  ramDataOut;
    logic        readSignal = 1'b0;
    logic        writeSignal = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bytes whose content the bench knows, plus status flags.
    logic [7:0]  mdl [int];
    bit          m_err = 0, m_img = 0, m_par = 0;
    logic [15:0] wq [$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } hdr_vec_t;
    hdr_vec_t hv [6];

    always #5 clk = ~clk;

    cnn_io_coordinator #(.ADDR_W(16), .DATA_W(8), .MAX_RUN(32)) dut (
        .clk(clk), .RST(RST), .interrupt(interrupt), .load(load), .cnn(cnn),
        .Din(Din), .Dout(Dout), .ramAddress(ramAddress), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut), .readSignal(readSignal), .writeSignal(writeSignal)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input bit dec);
        check(name, 32'(Dout), 32'({m_err, m_img, m_par, dec}));
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
        ramAddress = a; ramDataIn = d; writeSignal = 1'b1;
        tick();
        writeSignal = 1'b0;
        mdl[int'(a)] = d;
    endtask

    task automatic host_rd(input logic [15:0] a, output logic [7:0] d);
        ramAddress = a; readSignal = 1'b1;
        tick();
        readSignal = 1'b0;
        d = ramDataOut;
    endtask

    task automatic rd_check(input logic [15:0] a);
        logic [7:0] d;
        host_rd(a, d);
        if (mdl.exists(int'(a))) check($sformatf("rd[%0h]", a), 32'(d), 32'(mdl[int'(a)]));
        else check($sformatf("model_has[%0h]", a), 32'd0, 32'd1);
    endtask

    // Decompression rule: min(run, MAX_RUN) copies of value from ptr upward.
    task automatic model_word(inout logic [15:0] ptr, input logic [15:0] w);
        int n;
        n = (int'(w[15:8]) > MAXR) ? MAXR : int'(w[15:8]);
        if (int'(w[15:8]) > MAXR) m_err = 1;
        for (int k = 0; k < n; k++) begin
            mdl[int'(ptr)] = w[7:0];
            ptr = ptr + 16'd1;
        end
    endtask

    task automatic img_load(input logic [15:0] base);
        logic [15:0] p;
        p = base;
        ramAddress = base; cnn = 1'b0; load = 1'b1;
        foreach (wq[i]) begin
            Din = wq[i];
            model_word(p, wq[i]);
            tick(WORD_CYC);
        end
        load = 1'b0;
        tick(2);
        m_img = 1;
    endtask

    initial begin
        logic [7:0]  d;
        logic [15:0] base, a;
        logic [15:0] pq [$];

        // Reset
        RST = 1'b0;
        tick(2);
        check("rst_dout", 32'(Dout), 32'h0);
        check("rst_rdata", 32'(ramDataOut), 32'h0);
        RST = 1'b1;
        tick();

        // Header write/read table
        hv[0] = '{16'(HDR_FILTER_SIZE),   8'h01, 8'h01};
        hv[1] = '{16'(HDR_NUM_LAYERS),    8'h03, 8'h03};
        hv[2] = '{16'(HDR_FILT_OFS),      8'h00, 8'h00};
        hv[3] = '{16'(HDR_FILT_OFS + 1),  8'h0B, 8'h0B};
        hv[4] = '{16'(HDR_DENSE_OFS),     8'h01, 8'h01};
        hv[5] = '{16'(HDR_COUNTS),        8'h08, 8'h08};
        for (int i = 0; i < 6; i++) host_wr(hv[i].addr, hv[i].wdata);
        for (int i = 0; i < 6; i++) begin
            host_rd(hv[i].addr, d);
            check($sformatf("hdr[%0d]", i), 32'(d), 32'(hv[i].exp));
        end
        // ramDataOut holds without a strobe
        ramAddress = 16'd1;
        tick();
        check("rd_hold", 32'(ramDataOut), 32'h08);
        // Read and write of the same address in one cycle returns the old byte
        ramAddress = 16'd1; ramDataIn = 8'h44; writeSignal = 1'b1; readSignal = 1'b1;
        tick();
        writeSignal = 1'b0; readSignal = 1'b0;
        check("rd_old", 32'(ramDataOut), 32'h03);
        mdl[1] = 8'h44;
        rd_check(16'd1);

        // Parameter load
        host_wr(16'd15, 8'h3C);
        host_wr(16'd16, 8'h3C);
        ramAddress = 16'd11; Din = 16'hABCD; cnn = 1'b1; load = 1'b1;
        tick(2);
        ramAddress = 16'd13; Din = 16'h1234;
        tick(2);
        load = 1'b0;
        tick(2);
        mdl[11] = 8'hAB; mdl[12] = 8'hCD; mdl[13] = 8'h12; mdl[14] = 8'h34;
        m_par = 1;
        chk_status("par_done", 0);
        // Partial word: only the HI byte lands
        ramAddress = 16'd15; Din = 16'h9876; load = 1'b1;
        tick();
        load = 1'b0;
        tick(2);
        mdl[15] = 8'h98;
        for (int i = 11; i <= 16; i++) rd_check(16'(i));

        // Image decompress with mid-stream probes and write arbitration
        for (int i = 100; i <= 110; i++) host_wr(16'(i), 8'h5A);
        base = 16'd100;
        ramAddress = 16'd100; Din = 16'h05FF; cnn = 1'b0; load = 1'b1;
        tick(2);
        chk_status("dec_in_run", 1);
        model_word(base, 16'h05FF);
        tick(18);
        chk_status("dec_after_run", 0);
        rd_check(16'd104);
        rd_check(16'd105);
        tick(12);
        Din = 16'h0300;
        model_word(base, 16'h0300);
        tick(5);
        ramAddress = 16'd110; ramDataIn = 8'h99; writeSignal = 1'b1;
        tick();
        writeSignal = 1'b0;
        tick(28);
        load = 1'b0;
        tick(2);
        m_img = 1;
        chk_status("img_done", 0);
        for (int i = 100; i <= 110; i++) rd_check(16'(i));

        // Boundary: zero run and oversize run
        for (int i = 199; i <= 233; i++) host_wr(16'(i), 8'hC3);
        wq = '{16'h0000, 16'h2801};
        img_load(16'd200);
        chk_status("err_sat", 0);
        for (int i = 199; i <= 233; i++) rd_check(16'(i));

        // Interrupt mid-run
        for (int i = 300; i <= 319; i++) host_wr(16'(i), 8'h77);
        base = 16'd300;
        ramAddress = 16'd300; Din = 16'h14AA; cnn = 1'b0; load = 1'b1;
        tick(7);
        chk_status("pre_irq", 1);
        interrupt = 1'b1;
        tick();
        m_img = 0;
        chk_status("post_irq", 0);
        interrupt = 1'b0; load = 1'b0;
        tick(2);
        for (int i = 300; i <= 304; i++) mdl[i] = 8'hAA;
        mdl.delete(305);
        for (int i = 300; i <= 319; i++) if (i != 305) rd_check(16'(i));

        // Reset mid-operation
        for (int i = 400; i <= 420; i++) host_wr(16'(i), 8'h11);
        for (int i = 430; i <= 433; i++) host_wr(16'(i), 8'h22);
        rd_check(16'd300);
        ramAddress = 16'd400; Din = 16'h1055; cnn = 1'b0; load = 1'b1;
        tick(6);
        RST = 1'b0;
        tick();
        check("midrst_dout", 32'(Dout), 32'h0);
        check("midrst_rdata", 32'(ramDataOut), 32'h0);
        RST = 1'b1; load = 1'b0;
        m_err = 0; m_img = 0; m_par = 0;
        tick();
        chk_status("idle_after_rst", 0);
        for (int i = 400; i <= 403; i++) mdl[i] = 8'h55;
        mdl.delete(404);
        for (int i = 400; i <= 420; i++) if (i != 404) rd_check(16'(i));
        wq = '{16'h0366};
        img_load(16'd430);
        chk_status("restart_img", 0);
        for (int i = 430; i <= 433; i++) rd_check(16'(i));

        // Randomized host traffic
        for (int i = 0; i < 60; i++) begin
            a = 16'h1000 + 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) host_wr(a, 8'($urandom));
            else if (mdl.exists(int'(a))) rd_check(a);
        end

        // Randomized parameter words
        cnn = 1'b1; load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 16'h2000 + 16'(2 * $urandom_range(0, 127));
            Din = 16'($urandom);
            ramAddress = a;
            mdl[int'(a)] = Din[15:8];
            mdl[int'(a + 16'd1)] = Din[7:0];
            pq.push_back(a);
            tick(2);
        end
        load = 1'b0;
        tick(2);
        m_par = 1;
        chk_status("rnd_par", 0);
        foreach (pq[i]) begin
            rd_check(pq[i]);
            rd_check(pq[i] + 16'd1);
        end

        // Randomized compressed image
        base = 16'h3000 + 16'($urandom_range(0, 255));
        for (int i = 0; i <= 4 * MAXR; i++) host_wr(base + 16'(i), 8'hE7);
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back({8'($urandom_range(0, 40)), 8'($urandom)});
        img_load(base);
        chk_status("rnd_img", 0);
        for (int i = 0; i <= 4 * MAXR; i++) rd_check(base + 16'(i));

        // Pointer wrap at the top of memory
        host_wr(16'hFFFD, 8'h5C);
        wq = '{16'h04A5};
        img_load(16'hFFFE);
        rd_check(16'hFFFD);
        rd_check(16'hFFFE);
        rd_check(16'hFFFF);
        rd_check(16'h0000);
        rd_check(16'h0001);
        rd_check(16'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
